// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: drains the read side of the async FIFO and sends each word as a serial frame
// (start bit, data LSB first, optional parity, then stop bit(s)).
module fifo_rd_serializer #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_rd_clk,
  input  logic                 i_rd_rst_n,
  input  logic                 i_enable,
  input  logic                 i_empty,
  input  logic [DATA_SIZE-1:0] i_rd_data,
  output logic                 o_rd_en,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_tx_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_SIZE + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_SIZE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, POP, WAIT, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [BW-1:0] baud;
  logic [CW-1:0] bits;
  logic [DATA_SIZE-1:0] shift, shift_nxt;
  logic parity, bit_end, go;
  assign shift_nxt = shift >> 1;
  assign bit_end = baud == BAUD_LAST;
  assign go = i_enable && !i_empty;
  // o_tx is loaded one cycle ahead of each state change so the line is registered yet aligned to the state
  always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
    if (!i_rd_rst_n) begin
      state     <= IDLE;
      baud      <= '0;
      bits      <= '0;
      shift     <= '0;
      parity    <= 1'b0;
      o_tx      <= 1'b1;
      o_rd_en   <= 1'b0;
      o_busy    <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      o_rd_en   <= 1'b0;
      o_tx_done <= 1'b0;
      baud      <= (state inside {START, DATA, PARITY, STOP} && !bit_end) ? baud + 1'b1 : '0;
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (go) begin
            state   <= POP;
            o_rd_en <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        POP: state <= WAIT;
        WAIT: begin
          shift  <= i_rd_data;
          parity <= (^i_rd_data) ^ (PARITY_ODD != 0);
          o_tx   <= 1'b0;
          state  <= START;
        end
        START: if (bit_end) begin
          state <= DATA;
          o_tx  <= shift[0];
        end
        DATA: if (bit_end) begin
          shift <= shift_nxt;
          if (bits == DATA_LAST) begin
            bits  <= '0;
            state <= PARITY_EN != 0 ? PARITY : STOP;
            o_tx  <= PARITY_EN != 0 ? parity : 1'b1;
          end else begin
            bits <= bits + 1'b1;
            o_tx <= shift_nxt[0];
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          o_tx  <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (bits == STOP_LAST) begin
            bits      <= '0;
            o_tx_done <= 1'b1;
            state     <= go ? POP : IDLE;
            o_rd_en   <= go;
            o_busy    <= go;
          end else begin
            bits <= bits + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
